// File: rtl/mram_weight_fetch_dma_pkg.sv
// Shared types and constants for the MRAM weight-fetch DMA.
// Error codes, DMA FSM states and the fixed AXI encodings used on the read path.
package mram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DRAIN
  } dma_state_t;

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_ALIGN = 3'd1;
  localparam logic [2:0] ERR_RANGE = 3'd2;
  localparam logic [2:0] ERR_RSVD  = 3'd3;
  localparam logic [2:0] ERR_RESP  = 3'd4;
  localparam logic [2:0] ERR_LAST  = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

  localparam int BEAT_BYTES = 8;

endpackage

// File: rtl/mram_weight_fetch_dma_if.sv
// AXI4 read channels towards MRAM plus the weight stream to the loader.
// master = DMA side, slave = MRAM / loader side.
interface mram_weight_fetch_dma_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);

  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [7:0]            M_AXI_ARLEN;
  logic [2:0]            M_AXI_ARSIZE;
  logic [1:0]            M_AXI_ARBURST;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RLAST;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;
  logic [DATA_WIDTH-1:0] M_TDATA;
  logic                  M_TLAST;
  logic                  M_TVALID;
  logic                  M_TREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
    output M_AXI_ARBURST, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
    input  M_AXI_RVALID,
    output M_AXI_RREADY,
    output M_TDATA, M_TLAST, M_TVALID,
    input  M_TREADY
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
    input  M_AXI_ARBURST, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
    output M_AXI_RVALID,
    input  M_AXI_RREADY,
    input  M_TDATA, M_TLAST, M_TVALID,
    output M_TREADY
  );

endinterface

// File: rtl/mram_weight_fetch_dma_fifo.sv
// Output FIFO of the weight-fetch DMA (data plus TLAST sideband).
// Exposes a free-entry count so AR bursts are only issued with room reserved.
module dma_stream_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!count[AW] || do_pop);
  assign free    = {1'b1, {AW{1'b0}}} - count;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mram_weight_fetch_dma.sv
// AXI4 read burst master fetching weight tiles from MRAM into a
// valid/ready stream for the PE-array weight loader.
module mram_weight_fetch_dma
  import mram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  CFG_START,
  input  logic [ADDR_WIDTH-1:0] CFG_SRC_ADDR,
  input  logic [15:0]           CFG_BEATS,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [2:0]            ERR_CODE,
  mram_weight_fetch_dma_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  dma_state_t            state;
  dma_state_t            state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           remaining;
  logic [8:0]            len;
  logic [8:0]            len_q;
  logic [8:0]            beat_cnt;
  logic                  dropping;
  logic [2:0]            chk_err;
  logic [31:0]           job_end;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  final_beat;
  logic                  resp_bad;
  logic                  job_last;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic [AW:0]           free;
  logic [DATA_WIDTH:0]   fifo_in;
  logic [DATA_WIDTH:0]   fifo_out;

  assign len = (remaining > 16'(MAX_BURST)) ? 9'(MAX_BURST)
             : remaining[8:0];

  // Wide sum so a job ending past the top of MRAM cannot wrap.
  assign job_end = 32'(CFG_SRC_ADDR) + 32'(CFG_BEATS) * BEAT_BYTES;

  always_comb begin
    chk_err = ERR_OK;
    if (CFG_SRC_ADDR[2:0] != 3'd0)
      chk_err = ERR_ALIGN;
    else if (job_end > (32'd1 << ADDR_WIDTH))
      chk_err = ERR_RANGE;
  end

  assign bus.M_AXI_ARSIZE  = AXI_SIZE_8B;
  assign bus.M_AXI_ARBURST = AXI_BURST_INCR;
  assign bus.M_AXI_ARADDR  = addr;
  assign bus.M_AXI_ARLEN   = (state == AR) ? 8'(len - 9'd1) : 8'd0;
  assign bus.M_AXI_ARVALID = (state == AR) && (9'(free) >= len);
  assign bus.M_AXI_RREADY  = (state == R);

  assign ar_fire    = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
  assign r_fire     = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
  assign final_beat = (beat_cnt == len_q - 9'd1);
  assign resp_bad   = (bus.M_AXI_RRESP != AXI_RESP_OKAY);
  assign job_last   = (remaining == 16'(len_q));

  assign push    = r_fire && !dropping && !resp_bad;
  assign fifo_in = {final_beat && bus.M_AXI_RLAST && job_last,
                    bus.M_AXI_RDATA};
  assign pop     = bus.M_TVALID && bus.M_TREADY;

  assign bus.M_TVALID = !empty;
  assign bus.M_TDATA  = fifo_out[DATA_WIDTH-1:0];
  assign bus.M_TLAST  = fifo_out[DATA_WIDTH];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (CFG_START && chk_err == ERR_OK && CFG_BEATS != 16'd0)
          state_n = AR;
      AR:
        if (ar_fire) state_n = R;
      R:
        if (r_fire && bus.M_AXI_RLAST)
          state_n = (dropping || resp_bad || !final_beat || job_last)
                  ? DRAIN : AR;
      DRAIN:
        if (empty) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr      <= '0;
      remaining <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      dropping  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR_CODE  <= ERR_OK;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE:
          if (CFG_START) begin
            ERR_CODE <= chk_err;
            dropping <= 1'b0;
            if (chk_err != ERR_OK || CFG_BEATS == 16'd0) begin
              DONE <= 1'b1;
            end else begin
              addr      <= CFG_SRC_ADDR;
              remaining <= CFG_BEATS;
              BUSY      <= 1'b1;
            end
          end
        AR:
          if (ar_fire) begin
            addr     <= addr + ADDR_WIDTH'(32'(len) * BEAT_BYTES);
            len_q    <= len;
            beat_cnt <= '0;
          end
        R:
          if (r_fire) begin
            beat_cnt <= beat_cnt + 9'd1;
            // Once a burst goes bad, swallow its remaining beats.
            if (!dropping && resp_bad) begin
              dropping <= 1'b1;
              if (ERR_CODE == ERR_OK) ERR_CODE <= ERR_RESP;
            end else if (!dropping &&
                         (bus.M_AXI_RLAST != final_beat)) begin
              dropping <= 1'b1;
              if (ERR_CODE == ERR_OK) ERR_CODE <= ERR_LAST;
            end else if (!dropping && bus.M_AXI_RLAST) begin
              remaining <= remaining - 16'(len_q);
            end
          end
        DRAIN:
          if (empty) begin
            DONE <= 1'b1;
            BUSY <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  dma_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (push),
    .wdata (fifo_in),
    .pop   (pop),
    .rdata (fifo_out),
    .empty (empty),
    .free  (free)
  );

endmodule
